// File: rtl/uart_rx_cmd_seq.sv
// uart_rx_cmd_seq: parses UART bytes into register-file write/read frames and returns read data.
// Optional abort counter output err_cnt when RX_CMD_ERR_CNT_EN is defined.
module uart_rx_cmd_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int TO_W = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'd5000,
  parameter logic [DATA_W-1:0] CMD_WR = 8'hAA,
  parameter logic [DATA_W-1:0] CMD_RD = 8'hBB
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_abort
`ifdef RX_CMD_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);
  state_t state;
  logic [TO_W-1:0] cnt;
  logic in_frame, counting, took, abort;
  assign busy = state != IDLE;
  assign in_frame = state == WR_ADDR || state == WR_DATA || state == RD_ADDR;
  assign counting = in_frame || state == RD_WAIT;
  assign took = (in_frame && rx_valid) || (state == RD_WAIT && rf_rd_valid);
  // an accepted byte or read response beats a timeout landing in the same cycle
  assign abort = (in_frame && rx_err) || (counting && !took && TIMEOUT != '0 && cnt == TO_LAST);
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
      cnt <= '0;
      rf_addr <= '0;
      rf_wr_data <= '0;
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      frame_abort <= abort;
      cnt <= (counting && !took && !abort) ? ((&cnt) ? cnt : cnt + TO_W'(1)) : '0;
      if (abort) state <= IDLE;
      else case (state)
        IDLE:
          if (rx_valid && !rx_err)
            state <= rx_data == CMD_WR ? WR_ADDR : rx_data == CMD_RD ? RD_ADDR : IDLE;
        WR_ADDR, RD_ADDR:
          if (rx_valid) begin
            rf_addr <= rx_data[ADDR_W-1:0];
            rf_rd_en <= state == RD_ADDR;
            state <= state == RD_ADDR ? RD_WAIT : WR_DATA;
          end
        WR_DATA:
          if (rx_valid) begin
            rf_wr_data <= rx_data;
            rf_wr_en <= 1'b1;
            state <= IDLE;
          end
        RD_WAIT:
          if (rf_rd_valid) begin
            tx_data <= rf_rd_data;
            tx_valid <= 1'b1;
            state <= TX_SEND;
          end
        TX_SEND:
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RX_CMD_ERR_CNT_EN
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) err_cnt <= '0;
    else if (rf_wr_en && rf_addr == '0) err_cnt <= '0;
    else if (frame_abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule
